// File: rtl/rom_fetch_master.sv
// rtl/rom_fetch_master.sv - ROM fetch initiator with 1-cycle read tracking and 3-entry response FIFO
module rom_fetch_master #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  jmp_i,
    input  logic [31:0]           jmp_addr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [31:0]           instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
);

    logic [31:0]           fetch_pc;
    logic [31:0]           inflight_pc;
    logic                  inflight;
    logic                  kill;
    logic [31:0]           fifo_addr [3];
    logic [DATA_WIDTH-1:0] fifo_data [3];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [1:0]            count;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [31:0]           jmp_target;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A word is only requested when its response is guaranteed a FIFO slot,
    // without counting on a pop happening in the same cycle.
    assign issue         = !jmp_i && (({1'b0, count} + {2'b00, inflight}) <= 3'd2);
    assign push          = inflight && !kill;
    assign pop           = instr_valid_o && instr_ready_i;
    assign jmp_target    = jmp_addr_i & 32'hFFFF_FFFC;
    assign ram_addr      = fetch_pc[ADDR_WIDTH+1:2];
    assign instr_valid_o = (count != 2'd0);
    assign instr_o       = fifo_data[rd_ptr];
    assign instr_addr_o  = fifo_addr[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= BOOT_ADDR;
            inflight_pc <= 32'd0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
            count       <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_addr[i] <= 32'd0;
                fifo_data[i] <= '0;
            end
        end else if (jmp_i) begin
            // Redirect: buffered words and the response arriving now are dropped.
            fetch_pc <= jmp_target;
            inflight <= 1'b0;
            kill     <= inflight;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 2'd0;
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (push) begin
                fifo_addr[wr_ptr] <= inflight_pc;
                fifo_data[wr_ptr] <= ram_rdata;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assert property (@(posedge clk) disable iff (!rstn)
        ({1'b0, count} + {2'b00, inflight}) <= 3'd3);

endmodule

// File: tb/tb_rom_fetch_master.sv
// tb/tb_rom_fetch_master.sv - directed vector table plus randomized scoreboard for rom_fetch_master
module tb_rom_fetch_master;

    logic        clk;
    logic        rstn;
    logic [7:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic        jmp_i;
    logic [31:0] jmp_addr_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    logic [3:0]  ram_addr_w;
    logic [31:0] ram_rdata_w;
    logic        jmp_w;
    logic [31:0] jmp_addr_w;
    logic [31:0] instr_w;
    logic [31:0] instr_addr_w;
    logic        instr_valid_w;
    logic        ready_w;

    logic [31:0] rom   [256];
    logic [31:0] rom_w [16];

    int n_checks;
    int n_fail;

    rom_fetch_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BOOT_ADDR(32'h0)) dut (
        .clk(clk), .rstn(rstn), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .jmp_i(jmp_i), .jmp_addr_i(jmp_addr_i), .instr_o(instr_o),
        .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i)
    );

    rom_fetch_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BOOT_ADDR(32'h38)) dut_w (
        .clk(clk), .rstn(rstn), .ram_addr(ram_addr_w), .ram_rdata(ram_rdata_w),
        .jmp_i(jmp_w), .jmp_addr_i(jmp_addr_w), .instr_o(instr_w),
        .instr_addr_o(instr_addr_w), .instr_valid_o(instr_valid_w),
        .instr_ready_i(ready_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROMs with one cycle of latency.
    always @(posedge clk) begin
        ram_rdata   <= rom[ram_addr];
        ram_rdata_w <= rom_w[ram_addr_w];
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        jmp;
        logic [31:0] jaddr;
        logic        ev;
        logic [31:0] eaddr;
        logic [7:0]  eraddr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic ready, input logic jmp, input logic [31:0] jaddr,
                       input logic ev, input logic [31:0] eaddr, input logic [7:0] eraddr);
        vec_t v;
        v.rst = rst; v.ready = ready; v.jmp = jmp; v.jaddr = jaddr;
        v.ev = ev; v.eaddr = eaddr; v.eraddr = eraddr;
        vecs.push_back(v);
    endtask

    // Leaves the bench at the negedge that begins cycle 0 with rstn released.
    task automatic do_reset();
        rstn = 1'b0;
        jmp_i = 1'b0;
        instr_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_next;
        logic [31:0] tgt;
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic        r;
        logic        j;
        logic [31:0] ja;
        int          since;
        logic [3:0]  w_ra   [5];
        logic [31:0] w_addr [5];
        logic [31:0] w_data [5];

        n_checks   = 0;
        n_fail     = 0;
        rstn       = 1'b0;
        jmp_i      = 1'b0;
        jmp_addr_i = 32'd0;
        instr_ready_i = 1'b0;
        jmp_w      = 1'b0;
        jmp_addr_w = 32'd0;
        ready_w    = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = i * 16;
        for (int i = 0; i < 16; i++) rom_w[i] = 32'hA000 + i;

        @(negedge clk);
        check("reset_valid", {31'd0, instr_valid_o}, 32'd0);
        check("reset_instr", instr_o, 32'd0);
        check("reset_instr_addr", instr_addr_o, 32'd0);
        check("reset_ram_addr", {24'd0, ram_addr}, 32'd0);

        // Boot then backpressure on cycles 3..10.
        add(1, 1, 0, 0, 0, 0,  0);
        add(0, 1, 0, 0, 0, 0,  1);
        add(0, 1, 0, 0, 1, 0,  2);
        add(0, 0, 0, 0, 1, 4,  3);
        add(0, 0, 0, 0, 1, 4,  4);
        for (int c = 5; c <= 10; c++) add(0, 0, 0, 0, 1, 4, 4);
        add(0, 1, 0, 0, 1, 4,  4);
        add(0, 1, 0, 0, 1, 8,  4);
        add(0, 1, 0, 0, 1, 12, 5);
        add(0, 1, 0, 0, 1, 16, 6);
        add(0, 1, 0, 0, 1, 20, 7);
        add(0, 1, 0, 0, 1, 24, 8);
        // Jump to 0x43 in cycle 6 with ready held high.
        add(1, 1, 0, 0,     0, 0,     0);
        add(0, 1, 0, 0,     0, 0,     1);
        add(0, 1, 0, 0,     1, 0,     2);
        add(0, 1, 0, 0,     1, 4,     3);
        add(0, 1, 0, 0,     1, 8,     4);
        add(0, 1, 0, 0,     1, 12,    5);
        add(0, 1, 1, 32'h43, 1, 16,   6);
        add(0, 1, 0, 0,     0, 0,     8'h10);
        add(0, 1, 0, 0,     0, 0,     8'h11);
        add(0, 1, 0, 0,     1, 32'h40, 8'h12);
        add(0, 1, 0, 0,     1, 32'h44, 8'h13);
        add(0, 1, 0, 0,     1, 32'h48, 8'h14);
        // Jump while popping the head of a filled FIFO.
        add(1, 1, 0, 0,     0, 0,     0);
        add(0, 1, 0, 0,     0, 0,     1);
        add(0, 1, 0, 0,     1, 0,     2);
        add(0, 0, 0, 0,     1, 4,     3);
        add(0, 0, 0, 0,     1, 4,     4);
        add(0, 0, 0, 0,     1, 4,     4);
        add(0, 1, 1, 32'h81, 1, 4,    4);
        add(0, 1, 0, 0,     0, 0,     8'h20);
        add(0, 1, 0, 0,     0, 0,     8'h21);
        add(0, 1, 0, 0,     1, 32'h80, 8'h22);
        add(0, 1, 0, 0,     1, 32'h84, 8'h23);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            instr_ready_i = vecs[i].ready;
            jmp_i         = vecs[i].jmp;
            jmp_addr_i    = vecs[i].jaddr;
            check($sformatf("vec%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d_ram_addr", i), {24'd0, ram_addr}, {24'd0, vecs[i].eraddr});
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_addr", i), instr_addr_o, vecs[i].eaddr);
                check($sformatf("vec%0d_data", i), instr_o, rom[vecs[i].eaddr[9:2]]);
            end
            @(negedge clk);
        end

        // Address wrap on the 16-word instance booting at 0x38.
        w_ra[0] = 14; w_ra[1] = 15; w_ra[2] = 0; w_ra[3] = 1; w_ra[4] = 2;
        w_addr[2] = 32'h38; w_addr[3] = 32'h3C; w_addr[4] = 32'h40;
        w_data[2] = rom_w[14]; w_data[3] = rom_w[15]; w_data[4] = rom_w[0];
        do_reset();
        instr_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("wrap%0d_ram_addr", c), {28'd0, ram_addr_w}, {28'd0, w_ra[c]});
            check($sformatf("wrap%0d_valid", c), {31'd0, instr_valid_w}, (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check($sformatf("wrap%0d_addr", c), instr_addr_w, w_addr[c]);
                check($sformatf("wrap%0d_data", c), instr_w, w_data[c]);
            end
            @(negedge clk);
        end

        // Mid-run reset with buffered words and a request in flight.
        do_reset();
        instr_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        instr_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_pre_valid", {31'd0, instr_valid_o}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        check("midrst_instr_addr", instr_addr_o, 32'd0);
        check("midrst_ram_addr", {24'd0, ram_addr}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        instr_ready_i = 1'b1;
        check("midrst_c0_valid", {31'd0, instr_valid_o}, 32'd0);
        @(negedge clk);
        check("midrst_c1_valid", {31'd0, instr_valid_o}, 32'd0);
        @(negedge clk);
        check("midrst_c2_valid", {31'd0, instr_valid_o}, 32'd1);
        check("midrst_c2_addr", instr_addr_o, 32'd0);
        check("midrst_c2_data", instr_o, rom[0]);

        // Randomized stream against a word-order scoreboard.
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        do_reset();
        exp_next = 32'd0;
        tgt      = 32'd0;
        since    = 1;
        for (int c = 0; c < 3000; c++) begin
            v = instr_valid_o;
            a = instr_addr_o;
            d = instr_o;
            r  = ($urandom_range(0, 9) < 7);
            j  = ($urandom_range(0, 19) == 0);
            ja = $urandom;
            instr_ready_i = r;
            jmp_i         = j;
            jmp_addr_i    = ja;
            if (since == 1 || since == 2)
                check("rand_gap_valid", {31'd0, v}, 32'd0);
            else
                check("rand_stream_valid", {31'd0, v}, 32'd1);
            if (since == 3 && v)
                check("rand_target_addr", a, tgt);
            if (v && r) begin
                check("rand_pop_addr", a, exp_next);
                check("rand_pop_data", d, rom[exp_next[9:2]]);
                exp_next = exp_next + 32'd4;
            end
            if (j) begin
                tgt      = ja & 32'hFFFF_FFFC;
                exp_next = tgt;
                since    = 0;
            end
            if (since < 100) since++;
            @(negedge clk);
        end
        jmp_i = 1'b0;
        instr_ready_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_fetch_master.md
# rom_fetch_master

Initiator side of the single-way RAM/ROM read interface (`if_ram_1way`): drives word addresses into a synchronous-read ROM and returns the fetched words to the core as a valid/ready instruction stream. It keeps a fetch PC, tracks the one request in flight against the ROM's fixed 1-cycle read latency, and buffers responses in a 3-entry FIFO so consumer stalls never lose data. Jump requests flush all buffered and in-flight words and redirect fetching. It sits between the core's fetch stage and the ROM wrapper in both the testbench and the SoC.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: ROM word-address width; must match the ROM depth.
- `DATA_WIDTH`, 32: ROM word width.
- `BOOT_ADDR`, 32'h0000_0000: byte address of the first fetch after reset. Must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `ram_addr`  out  ADDR_WIDTH  word address to the ROM; equals `fetch_pc[ADDR_WIDTH+1:2]`.
- `ram_rdata`  in  DATA_WIDTH  ROM read data; valid in the cycle after its address was presented.
- `jmp_i`  in  1  redirect request, single-cycle pulse.
- `jmp_addr_i`  in  32  redirect byte address; bits [1:0] are ignored and forced to 0.
- `instr_o`  out  DATA_WIDTH  head-of-FIFO instruction word.
- `instr_addr_o`  out  32  byte address of `instr_o`.
- `instr_valid_o`  out  1  FIFO not empty.
- `instr_ready_i`  in  1  consumer accepts `instr_o` when it is high together with `instr_valid_o`.

## Operation
- Internal state: `fetch_pc` (32 b), `inflight` (1 b), `inflight_pc` (32 b), `kill` (1 b), and a 3-entry FIFO of {addr, data} with a 2-bit count.
- Issue condition in cycle N: `!jmp_i && (count + inflight + 1 <= 3)`. The pop in cycle N is not credited.
- On issue: at the edge, `inflight <= 1`, `inflight_pc <= fetch_pc`, and `fetch_pc <= fetch_pc + 4` (mod 2^32).
- No issue: `inflight <= 0`; `fetch_pc` holds; `ram_addr` keeps presenting `fetch_pc`. The resulting ROM reads are ignored.
- Response: if `inflight && !kill`, push {`inflight_pc`, `ram_rdata`} at the edge ending that cycle. If `kill` is set, discard the data.
- Pop: `instr_valid_o && instr_ready_i` at the edge. Simultaneous push and pop leaves count unchanged.
- Jump (`jmp_i`=1 in cycle J):
  - A pop in cycle J still completes.
  - The FIFO is then cleared (count <= 0).
  - `kill <= inflight`, which discards the request presented in J-1.
  - No issue occurs in J.
  - `fetch_pc <= {jmp_addr_i[31:2], 2'b00}`.
- `kill` clears after one cycle. Back-to-back jumps: the last one wins.
- The address wraps silently: `ram_addr` truncates `fetch_pc`, so the ROM space wraps at 2^ADDR_WIDTH words.
- The FIFO never overflows by construction. Assert `count + inflight <= 3` in simulation.

## Timing
- Reset values:
  - `fetch_pc` = BOOT_ADDR, so `ram_addr` = BOOT_ADDR[ADDR_WIDTH+1:2].
  - `instr_valid_o` = 0.
  - `instr_o` = 0.
  - `instr_addr_o` = 0.
  - `inflight` = 0.
  - `kill` = 0.
  - count = 0.
- Issue-to-valid latency: 2 cycles. Issue in N → data on `ram_rdata` in N+1 → `instr_valid_o` in N+2.
- First fetch: issued in the first cycle after `rstn` deasserts (cycle 0), so valid in cycle 2.
- Throughput: one word per cycle with `instr_ready_i` held high.
- Jump latency: `jmp_i` in J → target presented and issued in J+1 → target instruction valid in J+3. `instr_valid_o` is 0 in J+1 and J+2.
- Stall: with `instr_ready_i`=0, at most 3 words are accepted and issue stops. When ready returns, the next issue follows the first pop cycle.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). In-flight data is never pushed.

## Test plan
- Reset/boot: ROM[i]=i*16, BOOT_ADDR=0, ready=1 → valid from cycle 2 with `instr_o` = 0, 16, 32, … and `instr_addr_o` = 0, 4, 8, …, one word per cycle and no gaps.
- Backpressure: ready=0 for cycles 3–10 → count saturates at 3, `ram_addr` holds, no issue. When ready is restored, words continue in order with no loss or duplication.
- Jump: `jmp_i` with `jmp_addr_i`=0x43 in cycle 6 → valid low in cycles 7–8; cycle 9 gives `instr_addr_o`=0x40 and `instr_o`=ROM[16]. No pre-jump word appears after cycle 6.
- Jump with pop: in the same cycle as `jmp_i`, valid&ready → the head word is consumed exactly once, and the remainder is flushed.
- Wrap: ADDR_WIDTH=4, BOOT_ADDR=0x38 → `ram_addr` goes 14, 15, 0. `instr_addr_o` goes 0x38, 0x3C, 0x40 with data ROM[14], ROM[15], ROM[0].
- Mid-run reset: pull `rstn` low while the FIFO is full and a request is in flight → all outputs are at reset values before the next edge. Fetch restarts at BOOT_ADDR with the 2-cycle latency.
